// File: rtl/pipeline_interlock.sv
// Hazard and stall control for the 5-stage core: load-use interlock, data-memory
// wait freeze and taken-branch squash, plus stall/flush/load-use event counters.
module pipeline_interlock #(
  parameter int LOAD_USE_STALL = 1,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic             use_rs1_id,
  input  logic             use_rs2_id,
  input  logic [4:0]       rd_ex,
  input  logic             reg_we_ex,
  input  logic             load_ex,
  input  logic             mem_req_ma,
  input  logic             dmem_ready,
  input  logic             branch_taken_ex,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             stall_ma,
  output logic             bubble_ex,
  output logic             flush_if,
  output logic             flush_id,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic [CNT_W-1:0] lu_count
);

  typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT} state_t;

  localparam logic [2:0] LU_REM = 3'(LOAD_USE_STALL - 1);

  state_t     state, state_nxt, ret, ret_nxt, eff;
  logic [2:0] rem, rem_nxt;
  logic       hazard, memwait, lu_evt;

  assign hazard  = load_ex & reg_we_ex & (rd_ex != 5'd0) &
                   ((use_rs1_id & (rd_ex == rs1_id)) | (use_rs2_id & (rd_ex == rs2_id)));
  assign memwait = mem_req_ma & ~dmem_ready;

  // A memory freeze is transparent: once released, behave as the state it interrupted.
  assign eff = (state == MEM_WAIT) ? ret : state;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RUN;
      ret          <= RUN;
      rem          <= 3'd0;
      stall_cycles <= '0;
      flush_count  <= '0;
      lu_count     <= '0;
    end else begin
      state        <= state_nxt;
      ret          <= ret_nxt;
      rem          <= rem_nxt;
      stall_cycles <= stall_cycles + CNT_W'(stall_if);
      flush_count  <= flush_count + CNT_W'(flush_if);
      lu_count     <= lu_count + CNT_W'(lu_evt);
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    ret_nxt   = ret;
    rem_nxt   = rem;
    lu_evt    = 1'b0;
    if (memwait) begin
      state_nxt = MEM_WAIT;
      ret_nxt   = eff;
    end else begin
      case (eff)
        RUN: begin
          state_nxt = RUN;
          if (!branch_taken_ex && hazard) begin
            lu_evt = 1'b1;
            if (LOAD_USE_STALL > 1) begin
              rem_nxt   = LU_REM;
              state_nxt = LU_STALL;
            end
          end
        end
        LU_STALL: begin
          if (branch_taken_ex) begin
            state_nxt = RUN;
          end else begin
            rem_nxt   = rem - 3'd1;
            state_nxt = (rem <= 3'd1) ? RUN : LU_STALL;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  // Output logic
  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    stall_ex  = 1'b0;
    stall_ma  = 1'b0;
    bubble_ex = 1'b0;
    flush_if  = 1'b0;
    flush_id  = 1'b0;
    if (!reset) begin
      if (memwait) begin
        stall_if = 1'b1;
        stall_id = 1'b1;
        stall_ex = 1'b1;
        stall_ma = 1'b1;
      end else if (branch_taken_ex) begin
        flush_if = 1'b1;
        flush_id = 1'b1;
      end else if ((eff == LU_STALL) || (eff == RUN && hazard)) begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        bubble_ex = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_interlock.sv
// Scoreboard bench for pipeline_interlock: two instances (LOAD_USE_STALL=1 and 3)
// share the stimulus; expected controls and counters are queued per cycle.
module tb_pipeline_interlock;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs1_id, rs2_id, rd_ex;
  logic       use_rs1_id, use_rs2_id, reg_we_ex, load_ex;
  logic       mem_req_ma, dmem_ready, branch_taken_ex;

  logic        a_sif, a_sid, a_sex, a_sma, a_bub, a_fif, a_fid;
  logic [31:0] a_sc, a_fc, a_lc;
  logic        b_sif, b_sid, b_sex, b_sma, b_bub, b_fif, b_fid;
  logic [31:0] b_sc, b_fc, b_lc;

  pipeline_interlock #(.LOAD_USE_STALL(1), .CNT_W(32)) dut1 (
    .clk(clk), .reset(reset), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id), .rd_ex(rd_ex),
    .reg_we_ex(reg_we_ex), .load_ex(load_ex), .mem_req_ma(mem_req_ma),
    .dmem_ready(dmem_ready), .branch_taken_ex(branch_taken_ex),
    .stall_if(a_sif), .stall_id(a_sid), .stall_ex(a_sex), .stall_ma(a_sma),
    .bubble_ex(a_bub), .flush_if(a_fif), .flush_id(a_fid),
    .stall_cycles(a_sc), .flush_count(a_fc), .lu_count(a_lc));

  pipeline_interlock #(.LOAD_USE_STALL(3), .CNT_W(32)) dut3 (
    .clk(clk), .reset(reset), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id), .rd_ex(rd_ex),
    .reg_we_ex(reg_we_ex), .load_ex(load_ex), .mem_req_ma(mem_req_ma),
    .dmem_ready(dmem_ready), .branch_taken_ex(branch_taken_ex),
    .stall_if(b_sif), .stall_id(b_sid), .stall_ex(b_sex), .stall_ma(b_sma),
    .bubble_ex(b_bub), .flush_if(b_fif), .flush_id(b_fid),
    .stall_cycles(b_sc), .flush_count(b_fc), .lu_count(b_lc));

  always #5 clk = ~clk;

  // Control vector order: {stall_if, stall_id, stall_ex, stall_ma, bubble_ex, flush_if, flush_id}
  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_LU   = 7'b1100100;
  localparam logic [6:0] C_MW   = 7'b1111000;
  localparam logic [6:0] C_BR   = 7'b0000011;

  typedef struct {
    string       tag;
    bit          sel;
    logic [6:0]  ctl;
    logic [31:0] sc;
    logic [31:0] fc;
    logic [31:0] lc;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic drv(input logic ld, input logic we, input logic [4:0] rd,
                     input logic [4:0] r1, input logic [4:0] r2, input logic u1,
                     input logic u2, input logic mreq, input logic rdy, input logic br);
    load_ex = ld; reg_we_ex = we; rd_ex = rd; rs1_id = r1; rs2_id = r2;
    use_rs1_id = u1; use_rs2_id = u2; mem_req_ma = mreq; dmem_ready = rdy;
    branch_taken_ex = br;
  endtask

  task automatic idle();
    drv(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0);
  endtask

  task automatic ex(input string tag, input bit sel, input logic [6:0] ctl,
                    input int sc, input int fc, input int lc);
    exp_t e;
    e.tag = tag; e.sel = sel; e.ctl = ctl; e.sc = sc; e.fc = fc; e.lc = lc;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every queued expectation mid-cycle, away from the clock edge.
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      exp_t        e;
      logic [6:0]  act_ctl;
      logic [31:0] act_sc, act_fc, act_lc;
      e = sb_q.pop_front();
      if (e.sel) begin
        act_ctl = {b_sif, b_sid, b_sex, b_sma, b_bub, b_fif, b_fid};
        act_sc = b_sc; act_fc = b_fc; act_lc = b_lc;
      end else begin
        act_ctl = {a_sif, a_sid, a_sex, a_sma, a_bub, a_fif, a_fid};
        act_sc = a_sc; act_fc = a_fc; act_lc = a_lc;
      end
      checks++;
      if ({act_ctl, act_sc, act_fc, act_lc} !== {e.ctl, e.sc, e.fc, e.lc}) begin
        failures++;
        $display("FAIL %s n%0d: got ctl=%b sc=%0d fc=%0d lc=%0d, want ctl=%b sc=%0d fc=%0d lc=%0d",
                 e.tag, e.sel ? 3 : 1, act_ctl, act_sc, act_fc, act_lc,
                 e.ctl, e.sc, e.fc, e.lc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    idle();
    tick();
    // Reset forces outputs low even with a hazard presented
    drv(1, 1, 5'd5, 5'd5, 5'd0, 1, 0, 0, 1, 0);
    ex("rst_force", 0, C_NONE, 0, 0, 0); ex("rst_force", 1, C_NONE, 0, 0, 0);
    tick();
    reset = 1'b0;
    idle();
    ex("rst_idle", 0, C_NONE, 0, 0, 0); ex("rst_idle", 1, C_NONE, 0, 0, 0);
    tick();

    // Load-use on rs1
    drv(1, 1, 5'd5, 5'd5, 5'd0, 1, 0, 0, 1, 0);
    ex("lu_det", 0, C_LU, 0, 0, 0); ex("lu_det", 1, C_LU, 0, 0, 0);
    tick();
    idle();
    ex("lu_after", 0, C_NONE, 1, 0, 1); ex("lu3_b2", 1, C_LU, 1, 0, 1);
    tick();
    ex("lu_hold1", 0, C_NONE, 1, 0, 1); ex("lu3_b3", 1, C_LU, 2, 0, 1);
    tick();
    ex("lu3_done", 1, C_NONE, 3, 0, 1);
    tick();

    // x0 destination and unused source never stall
    drv(1, 1, 5'd0, 5'd0, 5'd0, 1, 1, 0, 1, 0);
    ex("x0", 0, C_NONE, 1, 0, 1); ex("x0", 1, C_NONE, 3, 0, 1);
    tick();
    drv(1, 1, 5'd7, 5'd0, 5'd7, 0, 0, 0, 1, 0);
    ex("nouse", 0, C_NONE, 1, 0, 1); ex("nouse", 1, C_NONE, 3, 0, 1);
    tick();
    // Store-style rs2 use does stall
    drv(1, 1, 5'd7, 5'd0, 5'd7, 0, 1, 0, 1, 0);
    ex("rs2_use", 0, C_LU, 1, 0, 1); ex("rs2_use", 1, C_LU, 3, 0, 1);
    tick();
    idle();
    ex("rs2_after", 0, C_NONE, 2, 0, 2); ex("rs2_b2", 1, C_LU, 4, 0, 2);
    tick();
    ex("rs2_b3", 1, C_LU, 5, 0, 2);
    tick();
    ex("rs2_done", 0, C_NONE, 2, 0, 2); ex("rs2_done", 1, C_NONE, 6, 0, 2);
    tick();

    // Branch beats hazard
    drv(1, 1, 5'd5, 5'd5, 5'd0, 1, 0, 0, 1, 1);
    ex("br_hz", 0, C_BR, 2, 0, 2); ex("br_hz", 1, C_BR, 6, 0, 2);
    tick();
    idle();
    ex("br_cnt", 0, C_NONE, 2, 1, 2); ex("br_cnt", 1, C_NONE, 6, 1, 2);
    tick();

    // Memory wait interrupting an LU_STALL (N=3, rem=2)
    drv(1, 1, 5'd5, 5'd5, 5'd0, 1, 0, 0, 1, 0);
    ex("mw_hz", 0, C_LU, 2, 1, 2); ex("mw_hz", 1, C_LU, 6, 1, 2);
    tick();
    for (int i = 0; i < 4; i++) begin
      drv(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0);
      ex("mw_frz", 0, C_MW, 3 + i, 1, 3); ex("mw_frz", 1, C_MW, 7 + i, 1, 3);
      tick();
    end
    idle();
    ex("mw_rel", 0, C_NONE, 7, 1, 3); ex("mw_rel_b2", 1, C_LU, 11, 1, 3);
    tick();
    ex("mw_rel_b3", 1, C_LU, 12, 1, 3);
    tick();
    ex("mw_done", 1, C_NONE, 13, 1, 3);
    tick();

    // Branch held through a memory freeze is not lost
    drv(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 1);
    ex("mw_br_frz", 1, C_MW, 13, 1, 3);
    tick();
    drv(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, 1);
    ex("mw_br_rel", 1, C_BR, 14, 1, 3);
    tick();
    idle();
    ex("mw_br_cnt", 1, C_NONE, 14, 2, 3);
    tick();

    // Reset in the middle of an LU_STALL
    drv(1, 1, 5'd5, 5'd5, 5'd0, 1, 0, 0, 1, 0);
    ex("mr_hz", 1, C_LU, 14, 2, 3);
    tick();
    idle();
    ex("mr_b2", 1, C_LU, 15, 2, 4);
    tick();
    reset = 1'b1;
    ex("mr_rst", 1, C_NONE, 16, 2, 4);
    tick();
    reset = 1'b0;
    ex("mr_clr", 1, C_NONE, 0, 0, 0);
    tick();
    drv(1, 1, 5'd5, 5'd5, 5'd0, 1, 0, 0, 1, 0);
    ex("mr_hz2", 1, C_LU, 0, 0, 0);
    tick();
    idle();
    ex("mr_b2_2", 1, C_LU, 1, 0, 1);
    tick();
    ex("mr_b3_2", 1, C_LU, 2, 0, 1);
    tick();
    ex("mr_end", 1, C_NONE, 3, 0, 1);
    tick();

    @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: got %0d pending, want 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
